// File: rtl/mcs_fpro_bridge.sv
// mcs_fpro_bridge: turns the strobe-based processor IO bus into registered single-cycle
// FPro transactions with window decode, programmable read latency and registered read return.
module mcs_fpro_bridge #(
    parameter logic [31:0] BRIDGE_BASE = 32'hC000_0000,
    parameter int          RD_LATENCY  = 0,
    parameter logic [31:0] MISS_DATA   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        io_addr_strobe,
    input  logic        io_read_strobe,
    input  logic        io_write_strobe,
    input  logic [3:0]  io_byte_enable,
    input  logic [31:0] io_address,
    input  logic [31:0] io_write_data,
    output logic [31:0] io_read_data,
    output logic        io_ready,
    output logic        fp_mmio_cs,
    output logic        fp_video_cs,
    output logic        fp_wr,
    output logic        fp_rd,
    output logic [20:0] fp_addr,
    output logic [31:0] fp_wr_data,
    input  logic [31:0] mmio_rd_data,
    input  logic [31:0] video_rd_data,
    output logic        miss_err
);
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;
    state_t      r_state, w_next;
    logic [2:0]  r_cnt, w_cnt_next;
    logic        r_is_wr, r_video, r_ready, r_miss;
    logic        r_mmio_cs, r_video_cs, r_fp_wr, r_fp_rd;
    logic [20:0] r_addr;
    logic [31:0] r_wdata, r_rdata;
    logic        w_hit, w_accept, w_miss, w_sample;
    logic        w_unused;
    // Direction is decided by the write strobe alone: both set is a write, neither is a read.
    assign w_unused = ^{io_read_strobe, io_byte_enable, io_address[1:0]};
    assign w_hit    = io_address[31:24] == BRIDGE_BASE[31:24];
    assign w_accept = r_state == IDLE && io_addr_strobe && w_hit;
    assign w_miss   = r_state == IDLE && io_addr_strobe && !w_hit;
    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_sample   = 1'b0;
        case (r_state)
            IDLE: if (io_addr_strobe) w_next = w_hit ? ACCESS : DONE;
            ACCESS: begin
                if (r_is_wr || RD_LATENCY == 0) begin
                    w_next   = DONE;
                    w_sample = !r_is_wr;
                end else begin
                    w_next     = WAIT;
                    w_cnt_next = 3'(RD_LATENCY - 1);
                end
            end
            WAIT: begin
                if (r_cnt == 3'd0) begin
                    w_next   = DONE;
                    w_sample = 1'b1;
                end else begin
                    w_cnt_next = r_cnt - 3'd1;
                end
            end
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_cnt      <= 3'd0;
            r_is_wr    <= 1'b0;
            r_video    <= 1'b0;
            r_ready    <= 1'b0;
            r_miss     <= 1'b0;
            r_mmio_cs  <= 1'b0;
            r_video_cs <= 1'b0;
            r_fp_wr    <= 1'b0;
            r_fp_rd    <= 1'b0;
            r_addr     <= 21'd0;
            r_wdata    <= 32'd0;
            r_rdata    <= 32'd0;
        end else begin
            r_state    <= w_next;
            r_cnt      <= w_cnt_next;
            r_ready    <= w_next == DONE;
            r_miss     <= w_miss;
            r_mmio_cs  <= w_accept && !io_address[23];
            r_video_cs <= w_accept && io_address[23];
            r_fp_wr    <= w_accept && io_write_strobe;
            r_fp_rd    <= w_accept && !io_write_strobe;
            if (w_accept) begin
                r_addr  <= io_address[22:2];
                r_wdata <= io_write_data;
                r_is_wr <= io_write_strobe;
                r_video <= io_address[23];
            end
            if (w_miss) r_rdata <= MISS_DATA;
            else if (w_sample) r_rdata <= r_video ? video_rd_data : mmio_rd_data;
        end
    end
    assign io_read_data = r_rdata;
    assign io_ready     = r_ready;
    assign miss_err     = r_miss;
    assign fp_mmio_cs   = r_mmio_cs;
    assign fp_video_cs  = r_video_cs;
    assign fp_wr        = r_fp_wr;
    assign fp_rd        = r_fp_rd;
    assign fp_addr      = r_addr;
    assign fp_wr_data   = r_wdata;
endmodule

// File: tb/tb_mcs_fpro_bridge.sv
// tb_mcs_fpro_bridge: three bridges (read latency 0, 2, 3) on shared inputs, checked
// every cycle against an event-schedule model plus directed vectors and sequences.
module tb_mcs_fpro_bridge;
    localparam int N = 3;
    localparam logic [31:0] MISS = 32'h0000_0000;
    logic clk = 1'b0;
    logic rst, as, rs, ws;
    logic [3:0] be;
    logic [31:0] addr, wdata, md_in, vd_in;
    logic [31:0] o_rdata [N];
    logic        o_ready [N], o_mcs [N], o_vcs [N], o_wr [N], o_rd [N], o_miss [N];
    logic [20:0] o_faddr [N];
    logic [31:0] o_fwd [N];
    for (genvar g = 0; g < N; g++) begin : g_dut
        mcs_fpro_bridge #(.RD_LATENCY(g == 0 ? 0 : g + 1)) u_dut (
            .clk(clk), .rst(rst),
            .io_addr_strobe(as), .io_read_strobe(rs), .io_write_strobe(ws),
            .io_byte_enable(be), .io_address(addr), .io_write_data(wdata),
            .io_read_data(o_rdata[g]), .io_ready(o_ready[g]),
            .fp_mmio_cs(o_mcs[g]), .fp_video_cs(o_vcs[g]), .fp_wr(o_wr[g]), .fp_rd(o_rd[g]),
            .fp_addr(o_faddr[g]), .fp_wr_data(o_fwd[g]),
            .mmio_rd_data(md_in), .video_rd_data(vd_in), .miss_err(o_miss[g])
        );
    end
    always #5 clk = ~clk;
    // Reference model: each accepted access is a set of scheduled cycle numbers.
    int          cyc, errors, checks;
    int          idle_at [N], acc_at [N], done_at [N], samp_at [N];
    logic        m_wr [N], m_vid [N], m_miss [N];
    logic [20:0] m_addr [N], e_faddr [N];
    logic [31:0] m_wd [N], m_samp [N], e_rdata [N], e_fwd [N];
    function automatic int lat(input int m);
        return (m == 0) ? 0 : m + 1;
    endfunction
    task automatic chk(input string name, input int m, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d cycle %0d: got %h expected %h", name, m, cyc, act, exp);
        end
    endtask
    task automatic model_reset();
        for (int m = 0; m < N; m++) begin
            idle_at[m] = 0; acc_at[m] = -1; done_at[m] = -1; samp_at[m] = -1;
            m_wr[m] = 1'b0; m_vid[m] = 1'b0; m_miss[m] = 1'b0;
            m_addr[m] = '0; m_wd[m] = '0; m_samp[m] = '0;
            e_faddr[m] = '0; e_fwd[m] = '0; e_rdata[m] = '0;
        end
    endtask
    task automatic step(input logic r, input logic s, input logic rr, input logic ww,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] md, input logic [31:0] vd);
        logic acc, dn;
        @(posedge clk);
        #1;
        cyc++;
        for (int m = 0; m < N; m++) begin
            acc = cyc == acc_at[m];
            dn  = cyc == done_at[m];
            if (acc) begin
                e_faddr[m] = m_addr[m];
                e_fwd[m]   = m_wd[m];
            end
            if (dn && (m_miss[m] || !m_wr[m])) e_rdata[m] = m_miss[m] ? MISS : m_samp[m];
            chk("ctl", m, {26'd0, o_ready[m], o_miss[m], o_mcs[m], o_vcs[m], o_wr[m], o_rd[m]},
                {26'd0, dn, dn && m_miss[m], acc && !m_vid[m], acc && m_vid[m], acc && m_wr[m], acc && !m_wr[m]});
            chk("fp_addr", m, {11'd0, o_faddr[m]}, {11'd0, e_faddr[m]});
            chk("fp_wr_data", m, o_fwd[m], e_fwd[m]);
            chk("io_read_data", m, o_rdata[m], e_rdata[m]);
        end
        rst = r; as = s; rs = rr; ws = ww; addr = a; wdata = d; md_in = md; vd_in = vd;
        be = 4'($urandom);
        if (!r) model_reset();
        else for (int m = 0; m < N; m++) begin
            if (cyc == samp_at[m]) m_samp[m] = m_vid[m] ? vd : md;
            if (s && cyc >= idle_at[m]) begin
                if (a[31:24] != 8'hC0) begin
                    m_miss[m] = 1'b1; acc_at[m] = -1; samp_at[m] = -1;
                    done_at[m] = cyc + 1;
                end else begin
                    m_miss[m] = 1'b0; m_wr[m] = ww; m_vid[m] = a[23];
                    m_addr[m] = a[22:2]; m_wd[m] = d;
                    acc_at[m]  = cyc + 1;
                    samp_at[m] = ww ? -1 : cyc + 1 + lat(m);
                    done_at[m] = cyc + 2 + (ww ? 0 : lat(m));
                end
                idle_at[m] = done_at[m] + 1;
            end
        end
    endtask
    task automatic idle(input logic [31:0] md, input logic [31:0] vd);
        step(1'b1, 1'b0, 1'($urandom), 1'($urandom), $urandom, $urandom, md, vd);
    endtask
    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] md;
        logic [31:0] vd;
        int          rdy;
        logic [4:0]  flags;
        logic [20:0] faddr;
        logic [31:0] rdata;
    } vec_t;
    vec_t tab [8];
    initial begin
        // flags = {mmio_cs, video_cs, fp_wr, fp_rd, miss_err} in cycle 1, for the latency-0 bridge
        tab[0] = '{1'b0, 1'b1, 32'hC000_0104, 32'h1234_5678, 32'h0, 32'h0, 2, 5'b10100, 21'h41, 32'h0};
        tab[1] = '{1'b1, 1'b0, 32'hC080_0008, 32'h0000_1111, 32'h0, 32'hA5A5_0001, 2, 5'b01010, 21'h2, 32'hA5A5_0001};
        tab[2] = '{1'b1, 1'b0, 32'h8000_0000, 32'h0, 32'h1, 32'h2, 1, 5'b00001, 21'h2, 32'h0};
        tab[3] = '{1'b1, 1'b1, 32'hC000_0020, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'h0, 2, 5'b10100, 21'h8, 32'h0};
        tab[4] = '{1'b0, 1'b0, 32'hC000_0030, 32'h0, 32'hCAFE_F00D, 32'h0, 2, 5'b10010, 21'hC, 32'hCAFE_F00D};
        tab[5] = '{1'b1, 1'b0, 32'hC0FF_FFFC, 32'h0, 32'h0, 32'h1357_9BDF, 2, 5'b01010, 21'h1F_FFFF, 32'h1357_9BDF};
        tab[6] = '{1'b1, 1'b0, 32'hC100_0000, 32'h0, 32'h3, 32'h4, 1, 5'b00001, 21'h1F_FFFF, 32'h0};
        tab[7] = '{1'b0, 1'b1, 32'hBFFF_FFFC, 32'h5, 32'h6, 32'h7, 1, 5'b00001, 21'h1F_FFFF, 32'h0};
        errors = 0; checks = 0; cyc = 0;
        rst = 1'b1; as = 1'b0; rs = 1'b0; ws = 1'b0; be = '0;
        addr = '0; wdata = '0; md_in = '0; vd_in = '0;
        model_reset();
        #1 rst = 1'b0;
        #1 chk("reset_state", 0, {31'd0, |{o_ready[0], o_miss[0], o_mcs[0], o_vcs[0], o_wr[0], o_rd[0], o_faddr[0], o_fwd[0], o_rdata[0]}}, 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
        foreach (tab[i]) begin
            step(1'b1, 1'b1, tab[i].rd, tab[i].wr, tab[i].a, tab[i].d, tab[i].md, tab[i].vd);
            for (int k = 1; k <= 7; k++) begin
                idle(tab[i].md, tab[i].vd);
                chk($sformatf("vec%0d_ready", i), 0, {31'd0, o_ready[0]}, {31'd0, k == tab[i].rdy});
                chk($sformatf("vec%0d_fp_addr", i), 0, {11'd0, o_faddr[0]}, {11'd0, tab[i].faddr});
                if (k == 1) chk($sformatf("vec%0d_flags", i), 0, {27'd0, o_mcs[0], o_vcs[0], o_wr[0], o_rd[0], o_miss[0]}, {27'd0, tab[i].flags});
                if (k == 1 && tab[i].rdy == 2) chk($sformatf("vec%0d_fp_wr_data", i), 0, o_fwd[0], tab[i].d);
                if (k >= tab[i].rdy) chk($sformatf("vec%0d_rdata", i), 0, o_rdata[0], tab[i].rdata);
            end
        end
        // Reset in the middle of a latency-3 read drops it without io_ready
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'hC000_0010, 32'h0, 32'h55, 32'h0);
        idle(32'h55, 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 32'h55, 32'h0);
        #1 chk("rst_mid_all_zero", 2, {31'd0, |{o_ready[2], o_miss[2], o_mcs[2], o_vcs[2], o_wr[2], o_rd[2], o_faddr[2], o_fwd[2], o_rdata[2]}}, 32'd0);
        chk("rst_mid_rdata0", 0, o_rdata[0], 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 32'h55, 32'h0);
        chk("rst_mid_no_ready", 2, {31'd0, o_ready[2]}, 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 32'h55, 32'h0);
        chk("rst_mid_no_ready", 2, {31'd0, o_ready[2]}, 32'd0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'hC000_0010, 32'h0, 32'h66, 32'h0);
        for (int k = 1; k <= 6; k++) begin
            idle(32'h66, 32'h0);
            chk("post_rst_ready", 2, {31'd0, o_ready[2]}, {31'd0, k == 5});
            if (k == 5) chk("post_rst_rdata", 2, o_rdata[2], 32'h66);
        end
        // Latency 2: data changes in cycle 3, sampled in the last wait cycle
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'hC000_0000, 32'h0, 32'h1, 32'h0);
        idle(32'h1, 32'h0);
        chk("lat_rd_c1", 1, {31'd0, o_rd[1]}, 32'd1);
        idle(32'h1, 32'h0);
        chk("lat_rd_c2", 1, {31'd0, o_rd[1]}, 32'd0);
        idle(32'h7, 32'h0);
        chk("lat_ready_c3", 1, {31'd0, o_ready[1]}, 32'd0);
        idle(32'h7, 32'h0);
        chk("lat_ready_c4", 1, {31'd0, o_ready[1]}, 32'd1);
        chk("lat_rdata_c4", 1, o_rdata[1], 32'h7);
        chk("lat_rd_c4", 1, {31'd0, o_rd[1]}, 32'd0);
        for (int k = 0; k < 3; k++) idle(32'h7, 32'h0);
        // Busy strobe ignored, then back-to-back accept right after io_ready
        step(1'b1, 1'b1, 1'b0, 1'b1, 32'hC000_0200, 32'hAAAA_0001, 0, 0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 32'hC000_0300, 32'hBBBB_0002, 0, 0);
        chk("busy_wr_c1", 0, {31'd0, o_wr[0]}, 32'd1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
        chk("busy_wr_c2", 0, {31'd0, o_wr[0]}, 32'd0);
        chk("busy_ready_c2", 0, {31'd0, o_ready[0]}, 32'd1);
        chk("busy_fwd_c2", 0, o_fwd[0], 32'hAAAA_0001);
        step(1'b1, 1'b1, 1'b0, 1'b1, 32'hC000_0400, 32'hCCCC_0003, 0, 0);
        chk("busy_ready_c3", 0, {31'd0, o_ready[0]}, 32'd0);
        chk("busy_wr_c3", 0, {31'd0, o_wr[0]}, 32'd0);
        idle(0, 0);
        chk("b2b_wr_c4", 0, {31'd0, o_wr[0]}, 32'd1);
        chk("b2b_faddr_c4", 0, {11'd0, o_faddr[0]}, {11'd0, 21'h100});
        chk("b2b_fwd_c4", 0, o_fwd[0], 32'hCCCC_0003);
        for (int k = 0; k < 6; k++) idle(0, 0);
        // Random traffic against the schedule model
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 199) != 0, $urandom_range(0, 2) == 0, 1'($urandom), 1'($urandom),
                 {($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hC0, 24'($urandom)},
                 $urandom, $urandom, $urandom);
        end
        for (int k = 0; k < 8; k++) idle($urandom, $urandom);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
